// File: rtl/tl_pkg.sv
// Shared types for the intersection phase scheduler.
// Lamp codes, phase encoding and lamp decode helpers.
package tl_pkg;

  localparam int LAMP_W = 2;

  localparam logic [LAMP_W-1:0] LAMP_RED = 2'b00;
  localparam logic [LAMP_W-1:0] LAMP_YEL = 2'b01;
  localparam logic [LAMP_W-1:0] LAMP_GRN = 2'b10;

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5
  } phase_t;

  function automatic logic [LAMP_W-1:0] lamp_a(phase_t p);
    logic [LAMP_W-1:0] l;
    l = LAMP_RED;
    if (p == A_GRN) l = LAMP_GRN;
    if (p == A_YEL) l = LAMP_YEL;
    return l;
  endfunction

  function automatic logic [LAMP_W-1:0] lamp_b(phase_t p);
    logic [LAMP_W-1:0] l;
    l = LAMP_RED;
    if (p == B_GRN) l = LAMP_GRN;
    if (p == B_YEL) l = LAMP_YEL;
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: CW-bit counter with clear, tick enable, saturation.
// Ports: i_clk, i_rstn (sync, active-low), clr_i, tick_i, cnt_o.
module phase_timer #(
  parameter int CW      = 4,
  parameter int MAX_CNT = 12
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          clr_i,
  input  logic          tick_i,
  output logic [CW-1:0] cnt_o
);

  localparam logic [CW-1:0] SAT = CW'(MAX_CNT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (tick_i && cnt_q != SAT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road phase scheduler: demand latches, min/max green, yellow, all-red.
// Ports: i_clk, i_rstn (sync, active-low), i_tick, i_ta, i_tb, i_hold,
//   i_preempt (only with PREEMPT_EN), o_la, o_lb, o_phase,
//   o_phase_start, o_dem_a, o_dem_b. Optional macro: PREEMPT_EN.
module intersection_phase_scheduler
  import tl_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALL_RED_T = 1,
  parameter int CW        = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_tick,
  input  logic              i_ta,
  input  logic              i_tb,
  input  logic              i_hold,
`ifdef PREEMPT_EN
  input  logic              i_preempt,
`endif
  output logic [LAMP_W-1:0] o_la,
  output logic [LAMP_W-1:0] o_lb,
  output logic [2:0]        o_phase,
  output logic              o_phase_start,
  output logic              o_dem_a,
  output logic              o_dem_b
);

  localparam logic [CW-1:0] MIN_M1 = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_M1 = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_M1 = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] AR_M1  = CW'(ALL_RED_T - 1);

  phase_t            state_q, state_d;
  logic [LAMP_W-1:0] la_q, lb_q;
  logic              ps_q;
  logic              dem_a_q, dem_a_d;
  logic              dem_b_q, dem_b_d;
  logic [CW-1:0]     cnt;
  logic              go_a, go_b, yel_done, red_done;

  phase_timer #(
    .CW      (CW),
    .MAX_CNT (MAX_GREEN)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .clr_i  (state_d != state_q),
    .tick_i (i_tick),
    .cnt_o  (cnt)
  );

  always_comb begin
    go_a = i_tick && !i_hold && dem_b_q && cnt >= MIN_M1
        && (!i_ta || cnt >= MAX_M1);
    go_b = i_tick && !i_hold && dem_a_q && cnt >= MIN_M1
        && (!i_tb || cnt >= MAX_M1);
    yel_done = i_tick && cnt == YEL_M1;
`ifdef PREEMPT_EN
    // Preemption forces green out at once and parks in all-red;
    // cnt keeps counting while parked, so the release test is >=.
    go_a = go_a || i_preempt;
    go_b = go_b || i_preempt;
    red_done = i_tick && !i_preempt && cnt >= AR_M1;
`else
    red_done = i_tick && cnt == AR_M1;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      A_GRN:   if (go_a)     state_d = A_YEL;
      A_YEL:   if (yel_done) state_d = RED_AB;
      RED_AB:  if (red_done) state_d = B_GRN;
      B_GRN:   if (go_b)     state_d = B_YEL;
      B_YEL:   if (yel_done) state_d = RED_BA;
      RED_BA:  if (red_done) state_d = A_GRN;
      default:               state_d = A_GRN;
    endcase
  end

  // Clear on entry overrides a same-cycle set.
  always_comb begin
    dem_a_d = dem_a_q;
    if (i_ta && state_q != A_GRN) dem_a_d = 1'b1;
    if (state_d == A_GRN && state_q != A_GRN) dem_a_d = 1'b0;
    dem_b_d = dem_b_q;
    if (i_tb && state_q != B_GRN) dem_b_d = 1'b1;
    if (state_d == B_GRN && state_q != B_GRN) dem_b_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= A_GRN;
      la_q    <= LAMP_GRN;
      lb_q    <= LAMP_RED;
      ps_q    <= 1'b0;
      dem_a_q <= 1'b0;
      dem_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      la_q    <= lamp_a(state_d);
      lb_q    <= lamp_b(state_d);
      ps_q    <= (state_d != state_q);
      dem_a_q <= dem_a_d;
      dem_b_q <= dem_b_d;
    end
  end

  assign o_la          = la_q;
  assign o_lb          = lb_q;
  assign o_phase       = state_q;
  assign o_phase_start = ps_q;
  assign o_dem_a       = dem_a_q;
  assign o_dem_b       = dem_b_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler.
// Covers reset, min/max green, hold, mid-phase reset, full cycle, preempt.
module tb_intersection_phase_scheduler;

  logic       i_clk;
  logic       i_rstn;
  logic       i_tick;
  logic       i_ta;
  logic       i_tb;
  logic       i_hold;
`ifdef PREEMPT_EN
  logic       i_preempt;
`endif
  logic [1:0] o_la;
  logic [1:0] o_lb;
  logic [2:0] o_phase;
  logic       o_phase_start;
  logic       o_dem_a;
  logic       o_dem_b;

  int total;
  int bad;

  localparam logic [2:0] P_AG = 3'd0;
  localparam logic [2:0] P_AY = 3'd1;
  localparam logic [2:0] P_RAB = 3'd2;
  localparam logic [2:0] P_BG = 3'd3;
  localparam logic [2:0] P_BY = 3'd4;
  localparam logic [2:0] P_RBA = 3'd5;
  localparam logic [1:0] L_R = 2'b00;
  localparam logic [1:0] L_Y = 2'b01;
  localparam logic [1:0] L_G = 2'b10;

  intersection_phase_scheduler dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_tick        (i_tick),
    .i_ta          (i_ta),
    .i_tb          (i_tb),
    .i_hold        (i_hold),
`ifdef PREEMPT_EN
    .i_preempt     (i_preempt),
`endif
    .o_la          (o_la),
    .o_lb          (o_lb),
    .o_phase       (o_phase),
    .o_phase_start (o_phase_start),
    .o_dem_a       (o_dem_a),
    .o_dem_b       (o_dem_b)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step(input logic t);
    i_tick = t;
    @(posedge i_clk);
    #1;
    i_tick = 1'b0;
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    step(1'b0);
    i_rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic bad_run;
    i_ta = 0; i_tb = 0; i_hold = 0;
    do_reset();
    total++;
    if (o_phase !== P_AG || o_la !== L_G || o_lb !== L_R) begin
      bad++;
      $display("FAIL reset_state phase=%0d la=%b lb=%b req 0 10 00",
               o_phase, o_la, o_lb);
    end
    total++;
    if (o_phase_start !== 1'b0 || o_dem_a !== 1'b0 || o_dem_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags ps=%b da=%b db=%b req 0 0 0",
               o_phase_start, o_dem_a, o_dem_b);
    end
    bad_run = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1);
      if (o_phase !== P_AG || o_phase_start !== 1'b0 || o_la !== L_G)
        bad_run = 1;
    end
    total++;
    if (bad_run !== 1'b0) begin
      bad++;
      $display("FAIL idle_20_ticks phase=%0d ps=%b req A_GRN no pulse",
               o_phase, o_phase_start);
    end
  endtask

  // Leaves the DUT in the first cycle of B_GRN.
  task automatic test_min_green();
    do_reset();
    step(1'b1);
    i_tb = 1;
    step(1'b1);
    i_tb = 0;
    total++;
    if (o_dem_b !== 1'b1 || o_phase !== P_AG) begin
      bad++;
      $display("FAIL dem_b_latch db=%b phase=%0d req 1 0", o_dem_b, o_phase);
    end
    step(1'b0);
    step(1'b1);
    total++;
    if (o_phase !== P_AG) begin
      bad++;
      $display("FAIL min_green_early phase=%0d req 0", o_phase);
    end
    step(1'b0);
    step(1'b1);
    total++;
    if (o_phase !== P_AY || o_la !== L_Y || o_lb !== L_R
        || o_phase_start !== 1'b1) begin
      bad++;
      $display("FAIL min_green_exit phase=%0d la=%b lb=%b ps=%b req 1 01 00 1",
               o_phase, o_la, o_lb, o_phase_start);
    end
    step(1'b1);
    total++;
    if (o_phase !== P_AY || o_phase_start !== 1'b0) begin
      bad++;
      $display("FAIL a_yel_hold phase=%0d ps=%b req 1 0",
               o_phase, o_phase_start);
    end
    step(1'b1);
    total++;
    if (o_phase !== P_RAB || o_la !== L_R || o_lb !== L_R
        || o_phase_start !== 1'b1) begin
      bad++;
      $display("FAIL red_ab phase=%0d la=%b lb=%b ps=%b req 2 00 00 1",
               o_phase, o_la, o_lb, o_phase_start);
    end
    step(1'b1);
    total++;
    if (o_phase !== P_BG || o_la !== L_R || o_lb !== L_G
        || o_phase_start !== 1'b1 || o_dem_b !== 1'b0) begin
      bad++;
      $display("FAIL b_grn_entry phase=%0d la=%b lb=%b ps=%b db=%b req 3 00 10 1 0",
               o_phase, o_la, o_lb, o_phase_start, o_dem_b);
    end
  endtask

  task automatic test_back_to_back();
    i_ta = 1;
    step(1'b1);
    i_ta = 0;
    step(1'b0);
    total++;
    if (o_phase_start !== 1'b0 || o_dem_a !== 1'b1 || o_phase !== P_BG) begin
      bad++;
      $display("FAIL b_grn_demand ps=%b da=%b phase=%0d req 0 1 3",
               o_phase_start, o_dem_a, o_phase);
    end
    step(1'b1);
    step(1'b1);
    total++;
    if (o_phase !== P_BG) begin
      bad++;
      $display("FAIL b_min_early phase=%0d req 3", o_phase);
    end
    step(1'b1);
    total++;
    if (o_phase !== P_BY || o_la !== L_R || o_lb !== L_Y) begin
      bad++;
      $display("FAIL b_yel phase=%0d la=%b lb=%b req 4 00 01",
               o_phase, o_la, o_lb);
    end
    step(1'b1);
    step(1'b1);
    total++;
    if (o_phase !== P_RBA || o_la !== L_R || o_lb !== L_R) begin
      bad++;
      $display("FAIL red_ba phase=%0d la=%b lb=%b req 5 00 00",
               o_phase, o_la, o_lb);
    end
    step(1'b1);
    total++;
    if (o_phase !== P_AG || o_la !== L_G || o_dem_a !== 1'b0
        || o_phase_start !== 1'b1) begin
      bad++;
      $display("FAIL a_grn_return phase=%0d la=%b da=%b ps=%b req 0 10 0 1",
               o_phase, o_la, o_dem_a, o_phase_start);
    end
  endtask

  task automatic test_max_green();
    do_reset();
    i_ta = 1;
    i_tb = 1;
    step(1'b1);
    i_tb = 0;
    for (int k = 1; k < 11; k++) step(1'b1);
    total++;
    if (o_phase !== P_AG) begin
      bad++;
      $display("FAIL max_green_early phase=%0d req 0", o_phase);
    end
    step(1'b1);
    total++;
    if (o_phase !== P_AY || o_dem_a !== 1'b0) begin
      bad++;
      $display("FAIL max_green_exit phase=%0d da=%b req 1 0",
               o_phase, o_dem_a);
    end
    step(1'b0);
    total++;
    if (o_dem_a !== 1'b1) begin
      bad++;
      $display("FAIL dem_a_in_yel da=%b req 1", o_dem_a);
    end
    i_ta = 0;
  endtask

  // Leaves the DUT in A_YEL with cnt=0 and dem_b still set.
  task automatic test_hold();
    logic bad_run;
    do_reset();
    i_tb = 1;
    step(1'b1);
    i_tb = 0;
    i_hold = 1;
    bad_run = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b1);
      if (o_phase !== P_AG) bad_run = 1;
    end
    total++;
    if (bad_run !== 1'b0 || o_dem_b !== 1'b1) begin
      bad++;
      $display("FAIL hold_30 phase=%0d db=%b req 0 1", o_phase, o_dem_b);
    end
    i_hold = 0;
    step(1'b1);
    total++;
    if (o_phase !== P_AY || o_phase_start !== 1'b1) begin
      bad++;
      $display("FAIL hold_release phase=%0d ps=%b req 1 1",
               o_phase, o_phase_start);
    end
  endtask

  task automatic test_reset_mid();
    i_ta = 1;
    step(1'b1);
    i_ta = 0;
    i_rstn = 0;
    step(1'b0);
    i_rstn = 1;
    total++;
    if (o_phase !== P_AG || o_la !== L_G || o_lb !== L_R
        || o_dem_a !== 1'b0 || o_dem_b !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset phase=%0d la=%b lb=%b da=%b db=%b req 0 10 00 0 0",
               o_phase, o_la, o_lb, o_dem_a, o_dem_b);
    end
    // Counter must restart at 0: exit lands on the fourth tick again.
    i_tb = 1;
    step(1'b1);
    i_tb = 0;
    step(1'b1);
    step(1'b1);
    total++;
    if (o_phase !== P_AG) begin
      bad++;
      $display("FAIL mid_reset_cnt phase=%0d req 0", o_phase);
    end
    step(1'b1);
    total++;
    if (o_phase !== P_AY) begin
      bad++;
      $display("FAIL mid_reset_exit phase=%0d req 1", o_phase);
    end
  endtask

`ifdef PREEMPT_EN
  task automatic test_preempt();
    logic bad_run;
    i_preempt = 0;
    test_min_green();
    i_preempt = 1;
    step(1'b0);
    total++;
    if (o_phase !== P_BY || o_lb !== L_Y || o_phase_start !== 1'b1) begin
      bad++;
      $display("FAIL preempt_exit phase=%0d lb=%b ps=%b req 4 01 1",
               o_phase, o_lb, o_phase_start);
    end
    step(1'b1);
    step(1'b1);
    total++;
    if (o_phase !== P_RBA) begin
      bad++;
      $display("FAIL preempt_red phase=%0d req 5", o_phase);
    end
    bad_run = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1);
      if (o_phase !== P_RBA || o_la !== L_R || o_lb !== L_R) bad_run = 1;
    end
    total++;
    if (bad_run !== 1'b0) begin
      bad++;
      $display("FAIL preempt_park phase=%0d req 5", o_phase);
    end
    i_preempt = 0;
    step(1'b0);
    total++;
    if (o_phase !== P_RBA) begin
      bad++;
      $display("FAIL preempt_wait_tick phase=%0d req 5", o_phase);
    end
    step(1'b1);
    total++;
    if (o_phase !== P_AG || o_la !== L_G) begin
      bad++;
      $display("FAIL preempt_resume phase=%0d la=%b req 0 10", o_phase, o_la);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    i_rstn = 0; i_tick = 0; i_ta = 0; i_tb = 0; i_hold = 0;
`ifdef PREEMPT_EN
    i_preempt = 0;
`endif
    test_reset();
    test_min_green();
    test_back_to_back();
    test_max_green();
    test_hold();
    test_reset_mid();
`ifdef PREEMPT_EN
    test_preempt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
